// File: rtl/cu_pkg.sv
// Shared types and helpers for the compute-unit issue scheduler.
// The reservation entry is sized by the package constants, which are also the top-level defaults.
package cu_pkg;

  localparam int CU_AW      = 4;
  localparam int CU_NFU     = 3;
  localparam int CU_MAX_LAT = 4;
  localparam int CU_LAT_W   = 3;

  typedef struct packed {
    logic              vld;
    logic [CU_NFU-1:0] fu;
    logic [CU_AW-1:0]  wadd;
  } cu_rsv_t;

  // A zero latency still needs one cycle; anything beyond the pipe depth is clamped.
  function automatic logic [CU_LAT_W-1:0] lat_clamp(input logic [CU_LAT_W-1:0] lat);
    if (lat == '0) return CU_LAT_W'(1);
    if (lat > CU_LAT_W'(CU_MAX_LAT)) return CU_LAT_W'(CU_MAX_LAT);
    return lat;
  endfunction

  function automatic logic is_onehot(input logic [CU_NFU-1:0] v);
    return (v != '0) && ((v & (v - CU_NFU'(1))) == '0);
  endfunction

endpackage

// File: rtl/cu_issue_sched_if.sv
// PS-side instruction handshake plus crossbar/functional-unit control bundle.
interface cu_issue_sched_if #(
  parameter int ADDRESS_WIDTH = 4,
  parameter int NUM_FU        = 3,
  parameter int LAT_W         = 3
);
  logic                     ps_cu_vld;
  logic [NUM_FU-1:0]        ps_cu_fu;
  logic [LAT_W-1:0]         ps_cu_lat;
  logic [ADDRESS_WIDTH-1:0] ps_cu_raddx;
  logic [ADDRESS_WIDTH-1:0] ps_cu_raddy;
  logic [ADDRESS_WIDTH-1:0] ps_cu_wadd;
  logic                     ps_cu_flush;

  logic                     cu_ps_rdy;
  logic                     cu_ps_err;
  logic                     cu_ps_busy;
  logic [NUM_FU-1:0]        cu_fu_en;
  logic [ADDRESS_WIDTH-1:0] cu_xb_raddx;
  logic [ADDRESS_WIDTH-1:0] cu_xb_raddy;
  logic [NUM_FU-1:0]        cu_xb_w_cuEn;
  logic [ADDRESS_WIDTH-1:0] cu_xb_wadd;

  modport master (
    output ps_cu_vld, ps_cu_fu, ps_cu_lat, ps_cu_raddx, ps_cu_raddy, ps_cu_wadd, ps_cu_flush,
    input  cu_ps_rdy, cu_ps_err, cu_ps_busy, cu_fu_en, cu_xb_raddx, cu_xb_raddy,
           cu_xb_w_cuEn, cu_xb_wadd
  );

  modport slave (
    input  ps_cu_vld, ps_cu_fu, ps_cu_lat, ps_cu_raddx, ps_cu_raddy, ps_cu_wadd, ps_cu_flush,
    output cu_ps_rdy, cu_ps_err, cu_ps_busy, cu_fu_en, cu_xb_raddx, cu_xb_raddy,
           cu_xb_w_cuEn, cu_xb_wadd
  );
endinterface

// File: rtl/cu_wb_pipe.sv
// Shifting writeback reservation pipe: slot 0 is the registered writeback, slots 1..MAX_LAT are future cycles.
// Insert and query indices refer to slot positions after this cycle's shift.
module cu_wb_pipe
  import cu_pkg::*;
#(
  parameter int MAX_LAT = CU_MAX_LAT,
  parameter int LAT_W   = CU_LAT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             ins_i,
  input  logic [LAT_W-1:0] ins_idx_i,
  input  cu_rsv_t          ins_ent_i,
  input  logic [LAT_W-1:0] qry_idx_i,
  output logic             qry_busy_o,
  output cu_rsv_t          wb_o
);

  cu_rsv_t [MAX_LAT:0] slot_q, slot_d;
  logic    [MAX_LAT:0] rsv_nxt;

  // Occupancy each slot will have after the shift; the top slot always frees up.
  for (genvar g = 0; g < MAX_LAT; g++) begin : g_nxt
    assign rsv_nxt[g] = slot_q[g+1].vld;
  end
  assign rsv_nxt[MAX_LAT] = 1'b0;

  assign qry_busy_o = rsv_nxt[qry_idx_i];

  always_comb begin
    for (int i = 0; i < MAX_LAT; i++) slot_d[i] = slot_q[i+1];
    slot_d[MAX_LAT] = '0;
    if (ins_i) slot_d[ins_idx_i] = ins_ent_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       slot_q <= '0;
    else if (flush_i) slot_q <= '0;
    else              slot_q <= slot_d;
  end

  assign wb_o = slot_q[0];

endmodule

// File: rtl/cu_issue_sched.sv
// Compute-unit issue/writeback scheduler: scoreboard hazard check, unit enable pulse,
// and single-slot register-file writeback reservation across NUM_FU variable-latency units.
module cu_issue_sched
  import cu_pkg::*;
#(
  parameter int ADDRESS_WIDTH = CU_AW,
  parameter int NUM_FU        = CU_NFU,
  parameter int MAX_LAT       = CU_MAX_LAT,
  parameter int LAT_W         = CU_LAT_W
) (
  input logic             clk,
  input logic             rst_n,
  cu_issue_sched_if.slave ifc
);

  localparam int DEPTH = 1 << ADDRESS_WIDTH;

  logic [DEPTH-1:0]         pend_q, pend_d;
  logic                     busy_q, err_q;
  logic [NUM_FU-1:0]        fu_en_q;
  logic [ADDRESS_WIDTH-1:0] raddx_q, raddy_q;

  logic [LAT_W-1:0] leff;
  logic             slot_busy, hazard, rdy, fu_ok, malformed, issue;
  cu_rsv_t          ins_ent, wb;

  assign leff      = lat_clamp(ifc.ps_cu_lat);
  // No bypass: a register writing back this cycle is still pending.
  assign hazard    = pend_q[ifc.ps_cu_raddx] | pend_q[ifc.ps_cu_raddy] |
                     pend_q[ifc.ps_cu_wadd]  | slot_busy;
  assign rdy       = ifc.ps_cu_vld & ~hazard & ~ifc.ps_cu_flush & rst_n;
  assign fu_ok     = is_onehot(ifc.ps_cu_fu);
  assign malformed = (ifc.ps_cu_fu != '0) & ~fu_ok;
  assign issue     = rdy & fu_ok;
  assign ins_ent   = '{vld: 1'b1, fu: ifc.ps_cu_fu, wadd: ifc.ps_cu_wadd};

  cu_wb_pipe #(
    .MAX_LAT (MAX_LAT),
    .LAT_W   (LAT_W)
  ) u_wb_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush_i    (ifc.ps_cu_flush),
    .ins_i      (issue),
    .ins_idx_i  (leff),
    .ins_ent_i  (ins_ent),
    .qry_idx_i  (leff),
    .qry_busy_o (slot_busy),
    .wb_o       (wb)
  );

  // Set after clear so a new owner of the same register wins over a stale writeback.
  always_comb begin
    pend_d = pend_q;
    if (wb.vld) pend_d[wb.wadd] = 1'b0;
    if (issue)  pend_d[ifc.ps_cu_wadd] = 1'b1;
    if (ifc.ps_cu_flush) pend_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q  <= '0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      fu_en_q <= '0;
      raddx_q <= '0;
      raddy_q <= '0;
    end else begin
      pend_q  <= pend_d;
      busy_q  <= |pend_d;
      err_q   <= rdy & malformed;
      fu_en_q <= issue ? ifc.ps_cu_fu : '0;
      if (issue) begin
        raddx_q <= ifc.ps_cu_raddx;
        raddy_q <= ifc.ps_cu_raddy;
      end
    end
  end

  assign ifc.cu_ps_rdy    = rdy;
  assign ifc.cu_ps_err    = err_q;
  assign ifc.cu_ps_busy   = busy_q;
  assign ifc.cu_fu_en     = fu_en_q;
  assign ifc.cu_xb_raddx  = raddx_q;
  assign ifc.cu_xb_raddy  = raddy_q;
  assign ifc.cu_xb_w_cuEn = wb.fu;
  assign ifc.cu_xb_wadd   = wb.wadd;

endmodule

// File: tb/tb_cu_issue_sched.sv
// Directed bench for cu_issue_sched: one cycle per table row, plus flush and async-reset sequences.
module tb_cu_issue_sched;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   applied = 0;
  int   miss = 0;

  always #5 clk = ~clk;

  cu_issue_sched_if #(.ADDRESS_WIDTH(4), .NUM_FU(3), .LAT_W(3)) ifc ();

  cu_issue_sched #(.ADDRESS_WIDTH(4), .NUM_FU(3), .MAX_LAT(4), .LAT_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ifc   (ifc)
  );

  typedef struct {
    logic       vld;
    logic [2:0] fu, lat;
    logic [3:0] rx, ry, wa;
    logic       rdy, err, busy;
    logic [2:0] fen, wen;
    logic [3:0] wad, xrx, xry;
  } vec_t;

  vec_t tv[$];

  task automatic add(input int vld, fu, lat, rx, ry, wa,
                     input int rdy, err, busy, fen, wen, wad, xrx, xry);
    vec_t v;
    v.vld = 1'(vld); v.fu = 3'(fu); v.lat = 3'(lat);
    v.rx = 4'(rx); v.ry = 4'(ry); v.wa = 4'(wa);
    v.rdy = 1'(rdy); v.err = 1'(err); v.busy = 1'(busy);
    v.fen = 3'(fen); v.wen = 3'(wen); v.wad = 4'(wad);
    v.xrx = 4'(xrx); v.xry = 4'(xry);
    tv.push_back(v);
  endtask

  task automatic idle(input int err, busy, fen, wen, wad, xrx, xry);
    add(0, 0, 0, 0, 0, 0, 0, err, busy, fen, wen, wad, xrx, xry);
  endtask

  task automatic drive(input int vld, fu, lat, rx, ry, wa, fl);
    ifc.ps_cu_vld   = 1'(vld);
    ifc.ps_cu_fu    = 3'(fu);
    ifc.ps_cu_lat   = 3'(lat);
    ifc.ps_cu_raddx = 4'(rx);
    ifc.ps_cu_raddy = 4'(ry);
    ifc.ps_cu_wadd  = 4'(wa);
    ifc.ps_cu_flush = 1'(fl);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    applied++;
    if (act != exp) begin
      miss++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // c0..c5 single issue; c6..c14 RAW stall; c15..c21 structural stall
    idle(0, 0, 0, 0, 0, 0, 0);
    add(1, 2, 2, 1, 2, 5,   1, 0, 0, 0, 0, 0, 0, 0);
    idle(0, 1, 2, 0, 0, 1, 2);
    idle(0, 1, 0, 0, 0, 1, 2);
    idle(0, 1, 0, 2, 5, 1, 2);
    idle(0, 0, 0, 0, 0, 1, 2);
    add(1, 1, 3, 3, 4, 7,   1, 0, 0, 0, 0, 0, 1, 2);
    add(1, 4, 1, 7, 0, 8,   0, 0, 1, 1, 0, 0, 3, 4);
    add(1, 4, 1, 7, 0, 8,   0, 0, 1, 0, 0, 0, 3, 4);
    add(1, 4, 1, 7, 0, 8,   0, 0, 1, 0, 0, 0, 3, 4);
    add(1, 4, 1, 7, 0, 8,   0, 0, 1, 0, 1, 7, 3, 4);
    add(1, 4, 1, 7, 0, 8,   1, 0, 0, 0, 0, 0, 3, 4);
    idle(0, 1, 4, 0, 0, 7, 0);
    idle(0, 1, 0, 4, 8, 7, 0);
    idle(0, 0, 0, 0, 0, 7, 0);
    add(1, 2, 3, 10, 11, 9,  1, 0, 0, 0, 0, 0, 7, 0);
    add(1, 1, 2, 13, 14, 12, 0, 0, 1, 2, 0, 0, 10, 11);
    add(1, 1, 2, 13, 14, 12, 1, 0, 1, 0, 0, 0, 10, 11);
    idle(0, 1, 1, 0, 0, 13, 14);
    idle(0, 1, 0, 2, 9, 13, 14);
    idle(0, 1, 0, 1, 12, 13, 14);
    idle(0, 0, 0, 0, 0, 13, 14);
    // c22..c23 malformed; c24..c31 latency clamp; c32..c34 no-op
    add(1, 3, 2, 0, 0, 3,   1, 0, 0, 0, 0, 0, 13, 14);
    idle(1, 0, 0, 0, 0, 13, 14);
    add(1, 4, 0, 1, 1, 6,   1, 0, 0, 0, 0, 0, 13, 14);
    add(1, 2, 7, 2, 3, 11,  1, 0, 1, 4, 0, 0, 1, 1);
    idle(0, 1, 2, 4, 6, 2, 3);
    idle(0, 1, 0, 0, 0, 2, 3);
    idle(0, 1, 0, 0, 0, 2, 3);
    idle(0, 1, 0, 0, 0, 2, 3);
    idle(0, 1, 0, 2, 11, 2, 3);
    idle(0, 0, 0, 0, 0, 2, 3);
    add(1, 0, 1, 0, 0, 4,   1, 0, 0, 0, 0, 0, 2, 3);
    idle(0, 0, 0, 0, 0, 2, 3);
    idle(0, 0, 0, 0, 0, 2, 3);

    // Reset state with a valid instruction presented
    drive(1, 1, 1, 0, 0, 1, 0);
    #12;
    chk("reset_rdy", int'(ifc.cu_ps_rdy), 0);
    chk("reset_outs", int'({ifc.cu_ps_err, ifc.cu_ps_busy, ifc.cu_fu_en, ifc.cu_xb_w_cuEn,
                            ifc.cu_xb_wadd, ifc.cu_xb_raddx, ifc.cu_xb_raddy}), 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    #10 rst_n = 1'b1;
    next_cycle();

    for (int i = 0; i < tv.size(); i++) begin
      drive(int'(tv[i].vld), int'(tv[i].fu), int'(tv[i].lat),
            int'(tv[i].rx), int'(tv[i].ry), int'(tv[i].wa), 0);
      @(negedge clk);
      applied++;
      if ({ifc.cu_ps_rdy, ifc.cu_ps_err, ifc.cu_ps_busy, ifc.cu_fu_en, ifc.cu_xb_w_cuEn,
           ifc.cu_xb_wadd, ifc.cu_xb_raddx, ifc.cu_xb_raddy} !==
          {tv[i].rdy, tv[i].err, tv[i].busy, tv[i].fen, tv[i].wen,
           tv[i].wad, tv[i].xrx, tv[i].xry}) begin
        miss++;
        $display("FAIL vec%0d rdy/err/busy/fen/wen/wad/xrx/xry: got %b/%b/%b/%b/%b/%0d/%0d/%0d want %b/%b/%b/%b/%b/%0d/%0d/%0d",
                 i, ifc.cu_ps_rdy, ifc.cu_ps_err, ifc.cu_ps_busy, ifc.cu_fu_en, ifc.cu_xb_w_cuEn,
                 ifc.cu_xb_wadd, ifc.cu_xb_raddx, ifc.cu_xb_raddy,
                 tv[i].rdy, tv[i].err, tv[i].busy, tv[i].fen, tv[i].wen,
                 tv[i].wad, tv[i].xrx, tv[i].xry);
      end
      next_cycle();
    end

    // Flush with three results in flight
    drive(1, 1, 4, 0, 0, 1, 0); @(negedge clk); chk("fl_iss0_rdy", int'(ifc.cu_ps_rdy), 1); next_cycle();
    drive(1, 2, 4, 0, 0, 2, 0); @(negedge clk); chk("fl_iss1_rdy", int'(ifc.cu_ps_rdy), 1); next_cycle();
    drive(1, 4, 4, 0, 0, 3, 0); @(negedge clk); chk("fl_iss2_rdy", int'(ifc.cu_ps_rdy), 1); next_cycle();
    drive(1, 1, 4, 9, 9, 9, 1);
    @(negedge clk);
    chk("fl_cycle_rdy", int'(ifc.cu_ps_rdy), 0);
    chk("fl_cycle_busy", int'(ifc.cu_ps_busy), 1);
    next_cycle();
    drive(1, 1, 1, 0, 0, 1, 0);
    @(negedge clk);
    chk("fl_after_rdy", int'(ifc.cu_ps_rdy), 1);
    chk("fl_after_busy", int'(ifc.cu_ps_busy), 0);
    chk("fl_after_wen", int'(ifc.cu_xb_w_cuEn), 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("fl_new_fen", int'(ifc.cu_fu_en), 1);
    chk("fl_old_wb1", int'(ifc.cu_xb_w_cuEn), 0);
    next_cycle();
    @(negedge clk);
    chk("fl_new_wb", int'({ifc.cu_xb_w_cuEn, ifc.cu_xb_wadd}), int'({3'd1, 4'd1}));
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("fl_no_wb", int'(ifc.cu_xb_w_cuEn), 0);
      next_cycle();
    end

    // Async reset with two results pending
    drive(1, 1, 3, 0, 0, 4, 0); @(negedge clk); chk("rs_iss0_rdy", int'(ifc.cu_ps_rdy), 1); next_cycle();
    drive(1, 2, 3, 0, 0, 5, 0); @(negedge clk); chk("rs_iss1_rdy", int'(ifc.cu_ps_rdy), 1); next_cycle();
    drive(1, 4, 1, 0, 0, 6, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("rs_rdy", int'(ifc.cu_ps_rdy), 0);
    chk("rs_busy", int'(ifc.cu_ps_busy), 0);
    chk("rs_fen", int'(ifc.cu_fu_en), 0);
    chk("rs_wb", int'({ifc.cu_xb_w_cuEn, ifc.cu_xb_wadd}), 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rs_no_wb", int'(ifc.cu_xb_w_cuEn), 0);
      chk("rs_idle_busy", int'(ifc.cu_ps_busy), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", applied, miss);
    $finish;
  end

endmodule
